// File: rtl/registry_rw.sv
// rtl/registry_rw.sv - UART command-frame register bank with optional readback
// Readback path (sRD_* states, tx_send/tx_data) present only when REGISTRY_READBACK_EN is defined.

module registry_rw #(
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_REG_WIDTH       = 16,
  parameter int C_REG_COUNT       = 16,
  parameter int C_TIMEOUT         = 100000
) (
  input  logic                                 clk,
  input  logic                                 rstb,
  input  logic                                 rx_valid,
  input  logic [C_UART_DATA_WIDTH-1:0]         rx_data,
  output logic                                 rx_ack,
  output logic [C_UART_DATA_WIDTH-1:0]         tx_data,
  output logic                                 tx_send,
  input  logic                                 tx_busy,
  output logic [C_REG_COUNT*C_REG_WIDTH-1:0]   register,
  output logic [C_REG_COUNT-1:0]               wr_strobe,
  output logic                                 err
);

  localparam int DW = C_UART_DATA_WIDTH;
  localparam int RW = C_REG_WIDTH;
  localparam int AW = DW - 1;
  localparam int NB = RW / DW;
  localparam int BW = $clog2(NB + 1);
  localparam int TW = $clog2(C_TIMEOUT + 1);
  localparam logic [C_REG_COUNT-1:0] STROBE_ONE = C_REG_COUNT'(1);

  typedef enum logic [2:0] {
    sIDLE,
    sCMD,
    sDATA,
    sCOMMIT
`ifdef REGISTRY_READBACK_EN
    , sRD_LOAD,
    sRD_SEND,
    sRD_WAIT
`endif
  } state_t;

  state_t                          state_q, state_d;
  logic                            armed_q, armed_d;
  logic                            rx_ack_q, rx_ack_d;
  logic [DW-1:0]                   rx_byte_q, rx_byte_d;
  logic [AW-1:0]                   addr_q, addr_d;
  logic [RW-1:0]                   stage_q, stage_d;
  logic [BW-1:0]                   bcnt_q, bcnt_d;
  logic [TW-1:0]                   tcnt_q, tcnt_d;
  logic [C_REG_COUNT*RW-1:0]       reg_q, reg_d;
  logic [C_REG_COUNT-1:0]          wr_strobe_q, wr_strobe_d;
  logic                            err_q, err_d;
  logic [RW-1:0]                   shift_q, shift_d;
  logic                            accept, sample, in_range;

  // A byte is taken only once rx_valid has been low since the previous one.
  assign accept   = (state_q == sIDLE) || (state_q == sDATA);
  assign sample   = rx_valid && armed_q && accept;
  assign in_range = (32'(addr_q) < C_REG_COUNT);

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    rx_ack_d    = sample;
    rx_byte_d   = sample ? rx_data : rx_byte_q;
    addr_d      = addr_q;
    stage_d     = stage_q;
    bcnt_d      = bcnt_q;
    reg_d       = reg_q;
    wr_strobe_d = '0;
    err_d       = 1'b0;
    shift_d     = shift_q;

    if (sample)         armed_d = 1'b0;
    else if (!rx_valid) armed_d = 1'b1;

    if (sample)                  tcnt_d = '0;
    else if (state_q == sDATA)   tcnt_d = tcnt_q + 1'b1;
    else                         tcnt_d = '0;

    case (state_q)
      sIDLE: if (sample) state_d = sCMD;
      sCMD: begin
        addr_d = rx_byte_q[AW-1:0];
        bcnt_d = '0;
        if (!rx_byte_q[DW-1]) begin
          state_d = sDATA;
        end else begin
`ifdef REGISTRY_READBACK_EN
          state_d = sRD_LOAD;
`else
          err_d   = 1'b1;
          state_d = sIDLE;
`endif
        end
      end
      sDATA: begin
        if (rx_ack_q) begin
          stage_d = (stage_q << DW) | RW'(rx_byte_q);
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == BW'(NB - 1)) state_d = sCOMMIT;
        end else if (!sample && tcnt_q == TW'(C_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          stage_d = '0;
          state_d = sIDLE;
        end
      end
      sCOMMIT: begin
        if (in_range) begin
          reg_d[addr_q*RW +: RW] = stage_q;
          wr_strobe_d            = STROBE_ONE << addr_q;
        end else begin
          err_d = 1'b1;
        end
        state_d = sIDLE;
      end
`ifdef REGISTRY_READBACK_EN
      sRD_LOAD: begin
        shift_d = in_range ? reg_q[addr_q*RW +: RW] : '0;
        err_d   = !in_range;
        bcnt_d  = '0;
        state_d = sRD_SEND;
      end
      sRD_SEND: if (tx_busy) state_d = sRD_WAIT;
      sRD_WAIT: begin
        if (!tx_busy) begin
          shift_d = shift_q << DW;
          bcnt_d  = bcnt_q + 1'b1;
          state_d = (bcnt_q == BW'(NB - 1)) ? sIDLE : sRD_SEND;
        end
      end
`endif
      default: state_d = sIDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= sIDLE;
      armed_q     <= 1'b0;
      rx_ack_q    <= 1'b0;
      rx_byte_q   <= '0;
      addr_q      <= '0;
      stage_q     <= '0;
      bcnt_q      <= '0;
      tcnt_q      <= '0;
      reg_q       <= '0;
      wr_strobe_q <= '0;
      err_q       <= 1'b0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      rx_ack_q    <= rx_ack_d;
      rx_byte_q   <= rx_byte_d;
      addr_q      <= addr_d;
      stage_q     <= stage_d;
      bcnt_q      <= bcnt_d;
      tcnt_q      <= tcnt_d;
      reg_q       <= reg_d;
      wr_strobe_q <= wr_strobe_d;
      err_q       <= err_d;
      shift_q     <= shift_d;
    end
  end

  assign rx_ack    = rx_ack_q;
  assign register  = reg_q;
  assign wr_strobe = wr_strobe_q;
  assign err       = err_q;

`ifdef REGISTRY_READBACK_EN
  assign tx_send = (state_q == sRD_SEND);
  assign tx_data = shift_q[RW-1 -: DW];
`else
  logic unused_readback;
  assign unused_readback = tx_busy ^ (^shift_q);
  assign tx_send = 1'b0;
  assign tx_data = '0;
`endif

endmodule

// File: tb/tb_registry_rw.sv
// tb/tb_registry_rw.sv - scoreboard bench for registry_rw (both REGISTRY_READBACK_EN builds)

module tb_registry_rw;

  localparam int DW = 8;
  localparam int RW = 16;
  localparam int RC = 16;
  localparam int TO = 50;

  localparam int EV_WR  = 0;
  localparam int EV_ERR = 1;
  localparam int EV_TX  = 2;

  logic              clk      = 1'b0;
  logic              rstb     = 1'b0;
  logic              rx_valid = 1'b0;
  logic [DW-1:0]     rx_data  = '0;
  logic              rx_ack;
  logic [DW-1:0]     tx_data;
  logic              tx_send;
  logic              tx_busy  = 1'b0;
  logic [RC*RW-1:0]  register;
  logic [RC-1:0]     wr_strobe;
  logic              err;

  typedef struct {
    int kind;
    int addr;
    int data;
    int lat;
  } ev_t;

  ev_t         sb[$];
  logic [RW-1:0] model [RC];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_ack_cyc = 0;
  int          ack_cnt = 0;
  int          base;

  registry_rw #(
    .C_UART_DATA_WIDTH(DW),
    .C_REG_WIDTH(RW),
    .C_REG_COUNT(RC),
    .C_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ack(rx_ack),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_busy(tx_busy),
    .register(register),
    .wr_strobe(wr_strobe),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pop_ev(output ev_t e);
    check("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{kind: -1, addr: 0, data: 0, lat: -1};
  endtask

  task automatic push_wr(input int a, input int d);
    sb.push_back('{kind: EV_WR, addr: a, data: d, lat: 2});
    model[a] = d[RW-1:0];
  endtask

  task automatic push_err(input int lat);
    sb.push_back('{kind: EV_ERR, addr: 0, data: 0, lat: lat});
  endtask

  task automatic push_tx(input int d, input int lat);
    sb.push_back('{kind: EV_TX, addr: 0, data: d, lat: lat});
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rx_ack_seen", 32'(rx_ack), 1);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < RC; i++)
      check($sformatf("%s_reg%0d", tag, i), 32'(register[i*RW +: RW]), 32'(model[i]));
  endtask

  task automatic drain(input int n, input string tag);
    repeat (n) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  // Write/error monitor: every strobe or err pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    ev_t e;
    if (rstb) begin
      if (rx_ack) begin
        ack_cnt++;
        last_ack_cyc = cyc;
      end
      if (wr_strobe != '0 || err) begin
        check("wr_err_excl", 32'((wr_strobe != '0) && err), 0);
        pop_ev(e);
        if (wr_strobe != '0) begin
          check("ev_kind_wr", e.kind, EV_WR);
          check("wr_strobe", 32'(wr_strobe), 32'(1) << e.addr);
          check("wr_value", 32'(register[e.addr*RW +: RW]), e.data);
          check("wr_latency", cyc - last_ack_cyc, 2);
        end else begin
          check("ev_kind_err", e.kind, EV_ERR);
          check("err_latency", cyc - last_ack_cyc, e.lat);
        end
      end
    end
  end

  // UART_Tx model: takes a byte, holds off, then raises tx_busy for a few cycles.
  always begin
    ev_t e;
    @(negedge clk);
    if (rstb && tx_send && !tx_busy) begin
      pop_ev(e);
      check("ev_kind_tx", e.kind, EV_TX);
      check("tx_data", 32'(tx_data), e.data);
      if (e.lat >= 0) check("tx_latency", cyc - last_ack_cyc, e.lat);
      repeat (2) begin
        @(negedge clk);
        check("tx_hold", 32'({tx_send, tx_data}), 32'({1'b1, e.data[7:0]}));
      end
      tx_busy = 1'b1;
      repeat (4) @(negedge clk);
      tx_busy = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < RC; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check_bank("reset");
    check("reset_outs", 32'({rx_ack, tx_send, wr_strobe, err, tx_data}), 0);

    base = ack_cnt;
    push_wr(3, 16'hABCD);
    send_byte(8'h03);
    send_byte(8'hAB);
    send_byte(8'hCD);
    drain(10, "t1_drain");
    check("t1_acks", ack_cnt - base, 3);
    check_bank("t1");

`ifdef REGISTRY_READBACK_EN
    base = ack_cnt;
    push_tx(8'hAB, 2);
    push_tx(8'hCD, -1);
    send_byte(8'h83);
    drain(40, "t2_drain");
    check("t2_acks", ack_cnt - base, 1);
    check_bank("t2");
`else
    base = ack_cnt;
    push_err(1);
    send_byte(8'h83);
    drain(20, "t6_drain");
    check("t6_acks", ack_cnt - base, 1);
    check("t6_tx_send", 32'(tx_send), 0);
    check_bank("t6");
`endif

    base = ack_cnt;
    push_err(2);
    send_byte(8'h20);
    send_byte(8'h11);
    send_byte(8'h22);
    drain(10, "t3_drain");
    check("t3_acks", ack_cnt - base, 3);
    check_bank("t3");

    push_err(TO);
    send_byte(8'h05);
    send_byte(8'h12);
    drain(60, "t4_timeout_drain");
    check_bank("t4_abort");
    push_wr(5, 16'h1122);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    drain(10, "t4_drain");
    check_bank("t4");

    send_byte(8'h07);
    send_byte(8'h99);
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    for (int i = 0; i < RC; i++) model[i] = '0;
    check_bank("t5_async");
    check("t5_outs", 32'({rx_ack, tx_send, wr_strobe, err, tx_data}), 0);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    push_wr(7, 16'h0102);
    send_byte(8'h07);
    send_byte(8'h01);
    send_byte(8'h02);
    drain(10, "t5_drain");
    check_bank("t5");

    check("sb_final", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/registry_rw.md
Name: registry_rw

Overview:
- Parametrised UART-fed register bank; successor to the single-byte, write-only debug registry.
- Decodes multi-byte command frames (command byte plus N data bytes) into C_REG_COUNT registers, each C_REG_WIDTH bits wide.
- Optionally returns register contents to the UART_Tx.
- Sits between UART_Rx/UART_Tx and the SDAD datapath control inputs.

Parameters:
C_UART_DATA_WIDTH, 8, UART word width [bit]; the command address field is C_UART_DATA_WIDTH-1 bits.
C_REG_WIDTH, 16, register width [bit]; must be an integer multiple of C_UART_DATA_WIDTH; C_REG_BYTES = C_REG_WIDTH/C_UART_DATA_WIDTH.
C_REG_COUNT, 16, number of registers; 1..2**(C_UART_DATA_WIDTH-1).
C_TIMEOUT, 100000, max clk cycles allowed between bytes of one frame before the frame is aborted.

Ports:
clk  in  1  master clock, all logic on rising edge.
rstb  in  1  reset, asynchronous, active low.
rx_valid  in  1  UART_Rx data valid.
rx_data  in  C_UART_DATA_WIDTH  UART_Rx byte.
rx_ack  out  1  one-cycle pulse: byte consumed.
tx_data  out  C_UART_DATA_WIDTH  byte to UART_Tx.
tx_send  out  1  request to UART_Tx.
tx_busy  in  1  UART_Tx transmitting.
register  out  C_REG_COUNT*C_REG_WIDTH  flattened bank; reg i occupies bits [(i+1)*C_REG_WIDTH-1 : i*C_REG_WIDTH].
wr_strobe  out  C_REG_COUNT  one-cycle pulse on bit i when reg i is updated.
err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (rstb low, asynchronous): all registers 0; rx_ack, tx_send, wr_strobe, err all 0; tx_data 0; FSM goes to sIDLE; timeout counter cleared. Any in-flight frame is discarded.
- Frame format:
  - Command byte: bit MSB = R/W (1 = read); low bits = address.
  - Write frame: command followed by C_REG_BYTES data bytes, MSB first.
  - Read frame: command byte only.
- Rx handshake:
  - A byte is sampled on the first clk edge where rx_valid=1 and the FSM accepts input.
  - rx_ack is registered and pulses high the following cycle.
  - The next byte is not sampled until rx_valid has been seen low at least one cycle.
- FSM states:
  - sIDLE -> sCMD on rx_valid.
  - sCMD: latch address and R/W. Write -> sDATA. Read -> sRD_LOAD.
  - sDATA: shift each byte into a staging register. After byte C_REG_BYTES -> sCOMMIT. On timeout -> sIDLE.
  - sCOMMIT: if address < C_REG_COUNT, load the register and pulse wr_strobe[addr]; otherwise pulse err. Then -> sIDLE.
  - sRD_LOAD: copy the register into a shift buffer (0 if address is out of range, plus an err pulse).
  - sRD_SEND: drive tx_data with the buffer MSB byte and hold tx_send=1 until tx_busy=1 is seen.
  - sRD_WAIT: wait for tx_busy=0. Shift the buffer; if bytes remain -> sRD_SEND, else -> sIDLE.
- Latencies:
  - Write: register output and wr_strobe valid 2 clk after the edge sampling the last data byte.
  - Read: first tx_send 2 clk after the command byte is sampled.
- Timeout:
  - The counter resets on every sampled byte and counts only in sDATA.
  - When it reaches C_TIMEOUT: pulse err, drop the staged data, return to sIDLE; registers are unchanged.
- Rx bytes arriving during sRD_*: not acked, and held pending until sIDLE. The Rx module flags any overrun.
- wr_strobe is one-hot or zero. err and wr_strobe are never high in the same cycle.

Optional Feature:
REGISTRY_READBACK_EN
- Defined: read frames execute as described above.
- Undefined:
  - sRD_* states are removed; tx_send and tx_data are tied 0.
  - A read command is acked, produces an err pulse, and the FSM returns to sIDLE.

Test Plan:
1. Defaults, bytes 0x03,0xAB,0xCD -> reg3=0xABCD, wr_strobe=0x0008 for exactly 1 cycle, three rx_ack pulses, all other registers 0.
2. After test 1, byte 0x83 (readback enabled) -> tx_data 0xAB then 0xCD, each with tx_send held until tx_busy rises; no further tx_send afterwards.
3. Bytes 0x20,0x11,0x22 -> all three acked, err single pulse, wr_strobe stays 0, bank unchanged.
4. C_TIMEOUT=50: bytes 0x05,0x12, then idle 60 cycles -> err pulse at cycle 50, reg5=0. Then 0x05,0x11,0x22 -> reg5=0x1122.
5. rstb low mid-frame after 0x07,0x99 -> bank zero immediately (asynchronous), outputs 0. After release, 0x07,0x01,0x02 -> reg7=0x0102.
6. REGISTRY_READBACK_EN undefined, byte 0x83 -> rx_ack pulse, err pulse, tx_send never asserted.
